// File: rtl/cpu_run_ctrl.sv
// Load-and-run controller: streams a program into instruction memory, then runs the core to a halt PC.
// Define CPU_RUN_CTRL_PERF_EN to build the non-NOP fetch counter behind inst_count (tied to 0 otherwise).
module cpu_run_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int CYC_W        = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int RST_HOLD     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] halt_pc,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] inst_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  inst_count
);

    // state   | meaning
    // IDLE    | waiting for load_start / start, core held in reset
    // LOAD    | accepting program words into instruction memory
    // RESET   | core held in reset for RST_HOLD cycles before running
    // RUN     | core running, watching fetch PC and cycle limit
    // DRAIN   | halt PC seen, letting the pipeline empty
    // DONE    | run finished, core frozen so its state can be read
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int TMR_MAX = (RST_HOLD > DRAIN_CYCLES) ? RST_HOLD : DRAIN_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] halt_q;
    logic [CYC_W-1:0]  limit_q;

    logic              xfer;
    logic              wr_at_top;
    logic              abort_go;
    logic              start_go;
    logic              halt_hit;
    logic              at_limit;
    logic [CYC_W-1:0]  cyc_inc;
    logic              unused_inst;

    assign ld_ready    = (state == S_LOAD);
    assign busy        = (state == S_LOAD) || (state == S_RESET) ||
                         (state == S_RUN)  || (state == S_DRAIN);
    assign xfer        = ld_ready & ld_valid;
    assign imem_we     = xfer;
    assign imem_waddr  = prog_len[ADDR_W-1:0];
    assign imem_wdata  = ld_data;
    assign wr_at_top   = &prog_len[ADDR_W-1:0];
    assign abort_go    = abort & (state != S_IDLE);
    assign start_go    = ((state == S_IDLE) || (state == S_DONE)) & ~abort_go & ~load_start &
                         start & (prog_len != '0);
    assign halt_hit    = (pc_in == halt_q);
    // limit_q holds max_cycles-1; a zero limit wraps to all-ones, i.e. a full 2^CYC_W run
    assign at_limit    = (cycle_count == limit_q);
    assign cyc_inc     = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    assign unused_inst = ^inst_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tmr         <= '0;
            halt_q      <= '0;
            limit_q     <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            load_err    <= 1'b0;
        end else if (abort_go) begin
            state     <= S_IDLE;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            if (state == S_LOAD) begin
                prog_len <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state     <= S_LOAD;
                        prog_len  <= '0;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_reset <= 1'b1;
                    end else if (start_go) begin
                        state       <= S_RESET;
                        tmr         <= RST_LOAD;
                        halt_q      <= halt_pc;
                        limit_q     <= max_cycles - 1'b1;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cpu_reset   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        prog_len <= prog_len + 1'b1;
                        if (ld_last) begin
                            state <= S_IDLE;
                        end else if (wr_at_top) begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_RESET: begin
                    if (tmr == '0) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RUN: begin
                    // a halt in the limit cycle still drains normally and reports done
                    if (halt_hit) begin
                        state       <= S_DRAIN;
                        tmr         <= DRAIN_LOAD;
                        cycle_count <= cyc_inc;
                    end else if (at_limit) begin
                        state     <= S_DONE;
                        timeout   <= 1'b1;
                        cpu_reset <= 1'b1;
                    end else begin
                        cycle_count <= cyc_inc;
                    end
                end
                S_DRAIN: begin
                    cycle_count <= cyc_inc;
                    if (at_limit) begin
                        timeout <= 1'b1;
                    end
                    if (tmr == '0) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef CPU_RUN_CTRL_PERF_EN
    // top nibble zero marks a NOP in this ISA
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_count <= '0;
        end else if (start_go) begin
            inst_count <= '0;
        end else if (((state == S_RUN) || (state == S_DRAIN)) &&
                     (inst_in[31:28] != 4'd0) && !(&inst_count)) begin
            inst_count <= inst_count + 1'b1;
        end
    end
`else
    assign inst_count = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: drivers push expected writes/results, a negedge monitor pops and compares.
module tb_cpu_run_ctrl;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int CYC_W    = 16;
    localparam int DRAIN    = 4;
    localparam int RST_HOLD = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start, ld_valid, ld_ready, ld_last, start, abort;
    logic [DATA_W-1:0] ld_data, inst_in, imem_wdata;
    logic [ADDR_W-1:0] halt_pc, pc_in, imem_waddr;
    logic [CYC_W-1:0]  max_cycles, cycle_count, inst_count;
    logic              imem_we, cpu_reset, busy, done, timeout, load_err;
    logic [ADDR_W:0]   prog_len;

    cpu_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W),
        .DRAIN_CYCLES(DRAIN), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .start(start),
        .abort(abort), .halt_pc(halt_pc), .max_cycles(max_cycles), .pc_in(pc_in),
        .inst_in(inst_in), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .timeout(timeout), .load_err(load_err), .prog_len(prog_len),
        .cycle_count(cycle_count), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int          end_cyc;
        logic        done;
        logic        timeout;
        logic        load_err;
        logic [8:0]  plen;
        logic [15:0] cc;
        logic [15:0] ic;
    } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    int   exp_rel[$];

    // reference model of the sticky status
    logic [8:0] m_plen = '0;
    logic       m_lerr = 1'b0;
    int         m_cc = 0;
    int         m_ic = 0;

    logic [7:0]  plan_pc   [0:511];
    logic [31:0] plan_inst [0:511];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic busy_q = 1'b0;
    logic crst_q = 1'b1;
    wr_t  w_mon;
    res_t r_mon;

    always @(negedge clk) begin
        if (!reset) begin
            busy_q = 1'b0;
            crst_q = 1'b1;
        end else begin
            if (imem_we === 1'b1) begin
                if (exp_wr.size() == 0) unexpected("write");
                else begin
                    w_mon = exp_wr.pop_front();
                    chk("wr_cycle", cyc, w_mon.cyc);
                    chk("wr_addr", imem_waddr, w_mon.a);
                    chk("wr_data", imem_wdata, w_mon.d);
                end
            end
            if (crst_q && cpu_reset === 1'b0) begin
                if (exp_rel.size() == 0) unexpected("cpu_reset_release");
                else chk("release_cycle", cyc, exp_rel.pop_front());
            end
            if (busy_q && busy === 1'b0) begin
                if (exp_res.size() == 0) unexpected("op_end");
                else begin
                    r_mon = exp_res.pop_front();
                    if (r_mon.end_cyc >= 0) chk("end_cycle", cyc, r_mon.end_cyc);
                    chk("done", done, r_mon.done);
                    chk("timeout", timeout, r_mon.timeout);
                    chk("load_err", load_err, r_mon.load_err);
                    chk("prog_len", prog_len, r_mon.plen);
                    chk("cycle_count", cycle_count, r_mon.cc);
                    chk("inst_count", inst_count, r_mon.ic);
                    chk("cpu_reset_idle", cpu_reset, 1);
                end
            end
            busy_q = busy;
            crst_q = cpu_reset;
        end
    end

    // ---------------- drivers / model ----------------
    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v[31:28] = 4'd0;
        return v;
    endfunction

    task automatic gen_plan(input bit ramp);
        for (int i = 0; i < 512; i++) begin
            plan_pc[i]   = ramp ? i[7:0] : 8'($urandom_range(0, 63));
            plan_inst[i] = rand_inst();
        end
    endtask

    task automatic load_op(input int n, input bit last, input bit toggle,
                           input bit with_start, input int abort_after);
        res_t r;
        wr_t  w;
        bit   ph;
        int   k;
        r.end_cyc = -1;
        r.done    = 1'b0;
        r.timeout = 1'b0;
        if (abort_after >= 0) begin
            r.plen     = '0;
            r.load_err = 1'b0;
        end else begin
            r.plen     = 9'(n);
            r.load_err = !last;
        end
        r.cc = 16'(m_cc);
        r.ic = 16'(m_ic);
        exp_res.push_back(r);
        load_start = 1'b1;
        start      = with_start;
        halt_pc    = 8'($urandom);
        max_cycles = 16'($urandom);
        tick();
        load_start = 1'b0;
        start      = 1'b0;
        k  = 0;
        ph = 1'b1;
        while (k < n) begin
            if (abort_after >= 0 && k == abort_after) begin
                ld_valid = 1'b0;
                abort    = 1'b1;
                tick();
                abort = 1'b0;
                break;
            end
            ld_data = $urandom;
            if (!toggle || ph) begin
                ld_valid = 1'b1;
                ld_last  = last && (k == n - 1);
                w.cyc = cyc;
                w.a   = k[7:0];
                w.d   = ld_data;
                exp_wr.push_back(w);
                k++;
            end else begin
                ld_valid = 1'b0;
                ld_last  = 1'($urandom_range(0, 1));
            end
            ph = !ph;
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        tick();
        m_plen = r.plen;
        m_lerr = r.load_err;
    endtask

    task automatic run_op(input logic [7:0] h, input logic [15:0] mx, input int abort_at);
        res_t r;
        int c, r0, lim, hit, active, cnt, ic, endc, idx;
        bit dn, to;
        lim = (mx == 16'd0) ? 65536 : int'(mx);
        hit = -1;
        for (int i = 0; i < lim && i < 512; i++) begin
            if (plan_pc[i] == h) begin
                hit = i;
                break;
            end
        end
        c  = cyc;
        r0 = c + RST_HOLD + 1;
        if (abort_at >= 0) begin
            active = abort_at + 1;
            cnt    = abort_at;
            dn     = 1'b0;
            to     = 1'b0;
            endc   = r0 + abort_at + 1;
        end else if (hit >= 0) begin
            active = hit + 1 + DRAIN;
            cnt    = hit + 1 + DRAIN;
            dn     = 1'b1;
            to     = (lim - 1 >= hit + 1) && (lim - 1 <= hit + DRAIN);
            endc   = r0 + 1 + hit + DRAIN;
        end else begin
            active = lim;
            cnt    = lim - 1;
            dn     = 1'b0;
            to     = 1'b1;
            endc   = r0 + lim;
        end
        ic = 0;
`ifdef CPU_RUN_CTRL_PERF_EN
        for (int j = 0; j < active && j < 512; j++) begin
            if (plan_inst[j][31:28] != 4'd0) ic++;
        end
`endif
        r.end_cyc  = endc;
        r.done     = dn;
        r.timeout  = to;
        r.load_err = m_lerr;
        r.plen     = m_plen;
        r.cc       = 16'(cnt);
        r.ic       = 16'(ic);
        exp_res.push_back(r);
        exp_rel.push_back(r0);
        start      = 1'b1;
        halt_pc    = h;
        max_cycles = mx;
        pc_in      = h;
        inst_in    = 32'hF000_0000;
        tick();
        start      = 1'b0;
        halt_pc    = ~h;
        max_cycles = 16'($urandom);
        while (cyc <= endc + 1) begin
            idx = cyc - r0;
            if (idx >= 0 && idx < 512 && cyc < endc) begin
                pc_in   = plan_pc[idx];
                inst_in = plan_inst[idx];
            end else begin
                pc_in   = h;
                inst_in = 32'hF000_0000;
            end
            abort = (abort_at >= 0) && (idx == abort_at);
            tick();
        end
        abort = 1'b0;
        m_cc  = cnt;
        m_ic  = ic;
    endtask

    task automatic start_ignored(input string tag);
        start      = 1'b1;
        halt_pc    = 8'($urandom);
        max_cycles = 16'd10;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0; start = 0; abort = 0;
        halt_pc = 0; max_cycles = 0; pc_in = 0; inst_in = 0;
        #2 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_inst_count", inst_count, 0);
        tick();

        start_ignored("empty_start");

        // 18-word load, start in the same cycle loses to load_start
        load_op(18, 1'b1, 1'b0, 1'b1, -1);
        gen_plan(1'b1);
        run_op(8'h12, 16'd100, -1);
        gen_plan(1'b1);
        run_op(8'hFF, 16'd50, -1);

        load_op($urandom_range(5, 40), 1'b1, 1'b1, 1'b0, -1);
        gen_plan(1'b1);
        run_op(8'd10, 16'd13, -1);

        // ten fetches with three NOPs, drain fetches are NOPs
        gen_plan(1'b1);
        for (int i = 0; i < 512; i++) plan_inst[i] = (i < 10) ? (32'h1000_0000 + i) : 32'h0;
        plan_inst[2] = 32'h0000_0013;
        plan_inst[5] = 32'h0000_0013;
        plan_inst[7] = 32'h0000_0013;
        run_op(8'd9, 16'd100, -1);

        for (int t = 0; t < 10; t++) begin
            gen_plan(1'b0);
            run_op(8'($urandom_range(0, 63)), 16'($urandom_range(1, 150)), -1);
        end

        load_op(256, 1'b0, 1'b0, 1'b0, -1);
        gen_plan(1'b1);
        run_op(8'h20, 16'd100, -1);

        gen_plan(1'b1);
        run_op(8'hFF, 16'd200, 30);

        load_op($urandom_range(1, 256), 1'b1, 1'b1, 1'b0, -1);
        gen_plan(1'b1);
        run_op(8'd100, 16'd0, -1);

        load_op(20, 1'b1, 1'b0, 1'b0, 7);
        start_ignored("after_load_abort");

        load_op(6, 1'b1, 1'b0, 1'b0, -1);
        gen_plan(1'b0);
        run_op(8'($urandom_range(0, 63)), 16'($urandom_range(1, 150)), -1);

        // async reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_t w;
            ld_valid = 1'b1;
            ld_data  = $urandom;
            w.cyc = cyc;
            w.a   = 8'(k);
            w.d   = ld_data;
            exp_wr.push_back(w);
            tick();
        end
        ld_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_prog_len", prog_len, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cpu_reset", cpu_reset, 1);
        tick();
        reset = 1'b1;
        m_plen = '0; m_lerr = 1'b0; m_cc = 0; m_ic = 0;
        tick();
        start_ignored("after_async_reset");

        repeat (5) tick();
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        chk("rel_queue_drained", exp_rel.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
